// File: rtl/proc_pkg.sv
// Shared definitions for the lab processor control path: opcodes, ALU selects,
// FSM state encoding and instruction field positions.
package proc_pkg;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_LOAD_A,
    S_LOAD_B,
    S_STORE,
    S_ALU,
    S_HALT
  } state_t;

  // Instruction field slices (16-bit instruction format)
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int LDADR_MSB = 11;
  localparam int LDADR_LSB = 4;
  localparam int STADR_MSB = 7;
  localparam int STADR_LSB = 0;
  localparam int RHI_MSB   = 11;
  localparam int RHI_LSB   = 8;
  localparam int RMID_MSB  = 7;
  localparam int RMID_LSB  = 4;
  localparam int RLO_MSB   = 3;
  localparam int RLO_LSB   = 0;

endpackage

// File: rtl/processor_controller.sv
// Fetch/decode/execute sequencer for the lab processor. Outputs are decoded
// from the state register and ir; only imem_ready feeds outputs directly.
module processor_controller
  import proc_pkg::*;
#(
  parameter int IR_W  = 16,
  parameter int DA_W  = 8,
  parameter int RA_W  = 4,
  parameter int ALU_W = 3
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             run,
  input  logic             imem_ready,
  input  logic [IR_W-1:0]  ir,
  output logic             pc_clear,
  output logic             pc_up,
  output logic             imem_rd,
  output logic             ir_load,
  output logic [DA_W-1:0]  d_addr,
  output logic             d_rd,
  output logic             d_wr,
  output logic             rf_s,
  output logic [RA_W-1:0]  rf_w_addr,
  output logic             rf_w_wr,
  output logic [RA_W-1:0]  rf_ra_addr,
  output logic [RA_W-1:0]  rf_rb_addr,
  output logic [ALU_W-1:0] alu_s,
  output logic             halted,
  output logic             illegal
);

  state_t     state;
  state_t     nxt;
  logic       illegal_q;
  logic [3:0] opcode;

  assign opcode  = ir[OPC_MSB:OPC_LSB];
  assign illegal = illegal_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= S_INIT;
      illegal_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_DECODE && opcode > OP_HALT)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_INIT:   if (run) nxt = S_FETCH;
      S_FETCH:  if (imem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOOP:        nxt = S_FETCH;
          OP_STORE:       nxt = S_STORE;
          OP_LOAD:        nxt = S_LOAD_A;
          OP_ADD, OP_SUB: nxt = S_ALU;
          default:        nxt = S_HALT;
        endcase
      end
      S_LOAD_A: nxt = S_LOAD_B;
      S_LOAD_B: nxt = S_FETCH;
      S_STORE:  nxt = S_FETCH;
      S_ALU:    nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_INIT;
    endcase
  end

  // Decoding from the async-reset state register makes strobes drop the
  // moment clear_n falls, so no partial memory/register write can complete.
  always_comb begin
    pc_clear   = 1'b0;
    pc_up      = 1'b0;
    imem_rd    = 1'b0;
    ir_load    = 1'b0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = '0;
    rf_w_wr    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    alu_s      = ALU_W'(ALU_PASS);
    halted     = 1'b0;
    case (state)
      S_INIT:  pc_clear = 1'b1;
      S_FETCH: begin
        imem_rd = 1'b1;
        ir_load = imem_ready;
        pc_up   = imem_ready;
      end
      S_LOAD_A: begin
        d_rd   = 1'b1;
        d_addr = DA_W'(ir[LDADR_MSB:LDADR_LSB]);
      end
      S_LOAD_B: begin
        d_rd      = 1'b1;
        d_addr    = DA_W'(ir[LDADR_MSB:LDADR_LSB]);
        rf_s      = 1'b1;
        rf_w_wr   = 1'b1;
        rf_w_addr = RA_W'(ir[RLO_MSB:RLO_LSB]);
      end
      S_STORE: begin
        d_wr       = 1'b1;
        d_addr     = DA_W'(ir[STADR_MSB:STADR_LSB]);
        rf_ra_addr = RA_W'(ir[RHI_MSB:RHI_LSB]);
      end
      S_ALU: begin
        rf_ra_addr = RA_W'(ir[RMID_MSB:RMID_LSB]);
        rf_rb_addr = RA_W'(ir[RLO_MSB:RLO_LSB]);
        rf_w_addr  = RA_W'(ir[RHI_MSB:RHI_LSB]);
        rf_w_wr    = 1'b1;
        alu_s      = (opcode == OP_SUB) ? ALU_W'(ALU_SUB) : ALU_W'(ALU_ADD);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_processor_controller.sv
// Self-checking bench for processor_controller: per-instruction cycle schedule
// model with directed and randomized instruction streams.
module tb_processor_controller;

  typedef struct packed {
    logic       pc_clear;
    logic       pc_up;
    logic       imem_rd;
    logic       ir_load;
    logic [7:0] d_addr;
    logic       d_rd;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] w_addr;
    logic       w_wr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       halted;
    logic       illegal;
  } out_t;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_ready = 1'b0;
  logic [15:0] ir = '0;
  logic        pc_clear, pc_up, imem_rd, ir_load, d_rd, d_wr, rf_s, rf_w_wr;
  logic        halted, illegal;
  logic [7:0]  d_addr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
  logic [2:0]  alu_s;
  logic [15:0] pc;
  out_t        obs;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  processor_controller #(.IR_W(16), .DA_W(8), .RA_W(4), .ALU_W(3)) dut (
    .clock(clock), .clear_n(clear_n), .run(run), .imem_ready(imem_ready),
    .ir(ir), .pc_clear(pc_clear), .pc_up(pc_up), .imem_rd(imem_rd),
    .ir_load(ir_load), .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr),
    .rf_s(rf_s), .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .alu_s(alu_s),
    .halted(halted), .illegal(illegal)
  );

  assign obs = {pc_clear, pc_up, imem_rd, ir_load, d_addr, d_rd, d_wr, rf_s,
                rf_w_addr, rf_w_wr, rf_ra_addr, rf_rb_addr, alu_s, halted, illegal};

  // Behavioural program counter: synchronous clear, +4 per up pulse
  always @(posedge clock) begin
    if (pc_clear) pc <= '0;
    else if (pc_up) pc <= pc + 16'd4;
  end

  // ---------------- reference model ----------------
  function automatic out_t o_init();
    out_t o = '0;
    o.pc_clear = 1'b1;
    return o;
  endfunction

  function automatic out_t o_fetch(input logic rdy);
    out_t o = '0;
    o.imem_rd = 1'b1;
    o.ir_load = rdy;
    o.pc_up   = rdy;
    return o;
  endfunction

  function automatic out_t o_halt(input logic ill);
    out_t o = '0;
    o.halted  = 1'b1;
    o.illegal = ill;
    return o;
  endfunction

  function automatic int n_exec(input logic [15:0] instr);
    case (instr[15:12])
      4'd1, 4'd3, 4'd4: return 1;
      4'd2:             return 2;
      default:          return 0;
    endcase
  endfunction

  function automatic out_t o_exec(input logic [15:0] instr, input int k);
    out_t o = '0;
    case (instr[15:12])
      4'd1: begin
        o.d_wr = 1'b1; o.d_addr = instr[7:0]; o.ra = instr[11:8];
      end
      4'd2: begin
        o.d_rd = 1'b1; o.d_addr = instr[11:4];
        if (k == 1) begin
          o.rf_s = 1'b1; o.w_wr = 1'b1; o.w_addr = instr[3:0];
        end
      end
      4'd3, 4'd4: begin
        o.ra = instr[7:4]; o.rb = instr[3:0]; o.w_addr = instr[11:8];
        o.w_wr = 1'b1; o.alu = (instr[15:12] == 4'd3) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
    return o;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic step(input logic r, input logic rdy, input logic [15:0] instr);
    @(negedge clock);
    run = r; imem_ready = rdy; ir = instr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_n = 1'b0; run = 1'b0; imem_ready = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== o_init()) begin
      n_bad++; $display("FAIL reset_async got=%h exp=%h", obs, o_init());
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 16'h0000);
      n_cmp++;
      if (obs !== o_init()) begin
        n_bad++; $display("FAIL init_hold[%0d] got=%h exp=%h", i, obs, o_init());
      end
    end
  endtask

  task automatic test_noop();
    do_reset();
    step(1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      out_t e;
      step(1'b0, 1'b1, 16'h0000);
      e = (i % 2 == 0) ? o_fetch(1'b1) : out_t'('0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL noop_cycle[%0d] got=%h exp=%h", i, obs, e);
      end
    end
    step(1'b0, 1'b0, 16'h0000);
    n_cmp++;
    if (pc !== 16'd12) begin
      n_bad++; $display("FAIL noop_pc got=%0d exp=12", pc);
    end
  endtask

  task automatic test_load();
    do_reset();
    step(1'b1, 1'b1, 16'h2A53);
    step(1'b0, 1'b1, 16'h2A53);
    step(1'b0, 1'b1, 16'h2A53);
    step(1'b0, 1'b1, 16'h2A53);
    n_cmp++;
    if (obs !== o_exec(16'h2A53, 0) || d_addr !== 8'hA5 || rf_w_wr !== 1'b0) begin
      n_bad++; $display("FAIL load_a got=%h exp=%h", obs, o_exec(16'h2A53, 0));
    end
    step(1'b0, 1'b1, 16'h2A53);
    n_cmp++;
    if (obs !== o_exec(16'h2A53, 1) || rf_w_addr !== 4'd3 || rf_s !== 1'b1) begin
      n_bad++; $display("FAIL load_b got=%h exp=%h", obs, o_exec(16'h2A53, 1));
    end
    step(1'b0, 1'b0, 16'h2A53);
    n_cmp++;
    if (obs !== o_fetch(1'b0)) begin
      n_bad++; $display("FAIL load_ret got=%h exp=%h", obs, o_fetch(1'b0));
    end
  endtask

  task automatic test_alu_fetch_wait();
    logic [15:0] instrs [2];
    logic [2:0]  sel [2];
    instrs[0] = 16'h3124; instrs[1] = 16'h4124;
    sel[0] = 3'b001;      sel[1] = 3'b010;
    do_reset();
    step(1'b1, 1'b0, 16'h0000);
    for (int n = 0; n < 2; n++) begin
      for (int w = 0; w < 3; w++) begin
        step(1'b0, 1'b0, instrs[n]);
        n_cmp++;
        if (obs !== o_fetch(1'b0)) begin
          n_bad++; $display("FAIL fetch_wait[%0d] got=%h exp=%h", w, obs, o_fetch(1'b0));
        end
      end
      step(1'b0, 1'b1, instrs[n]);
      n_cmp++;
      if (obs !== o_fetch(1'b1)) begin
        n_bad++; $display("FAIL fetch_ready got=%h exp=%h", obs, o_fetch(1'b1));
      end
      step(1'b0, 1'b1, instrs[n]);
      step(1'b0, 1'b0, instrs[n]);
      n_cmp++;
      if (obs !== o_exec(instrs[n], 0) || alu_s !== sel[n] || rf_ra_addr !== 4'd2 ||
          rf_rb_addr !== 4'd4 || rf_w_addr !== 4'd1) begin
        n_bad++; $display("FAIL alu_cycle got=%h exp=%h", obs, o_exec(instrs[n], 0));
      end
    end
    step(1'b0, 1'b0, 16'h0000);
    n_cmp++;
    if (pc !== 16'd8) begin
      n_bad++; $display("FAIL wait_pc got=%0d exp=8", pc);
    end
  endtask

  task automatic test_random();
    int nfetch = 0;
    do_reset();
    step(1'b1, 1'b0, 16'h0000);
    for (int n = 0; n < 40; n++) begin
      logic [15:0] instr;
      int waits;
      instr = {4'($urandom_range(0, 4)), 12'($urandom)};
      waits = $urandom_range(0, 2);
      for (int w = 0; w < waits; w++) begin
        step(1'($urandom), 1'b0, instr);
        n_cmp++;
        if (obs !== o_fetch(1'b0)) begin
          n_bad++; $display("FAIL rnd_wait[%0d] got=%h exp=%h", n, obs, o_fetch(1'b0));
        end
      end
      step(1'($urandom), 1'b1, instr);
      nfetch++;
      n_cmp++;
      if (obs !== o_fetch(1'b1)) begin
        n_bad++; $display("FAIL rnd_fetch[%0d] got=%h exp=%h", n, obs, o_fetch(1'b1));
      end
      step(1'($urandom), 1'($urandom), instr);
      n_cmp++;
      if (obs !== out_t'('0)) begin
        n_bad++; $display("FAIL rnd_decode[%0d] got=%h exp=0", n, obs);
      end
      for (int k = 0; k < n_exec(instr); k++) begin
        step(1'($urandom), 1'($urandom), instr);
        n_cmp++;
        if (obs !== o_exec(instr, k)) begin
          n_bad++; $display("FAIL rnd_exec[%0d.%0d] ir=%h got=%h exp=%h",
                            n, k, instr, obs, o_exec(instr, k));
        end
      end
    end
    step(1'b0, 1'b0, 16'h0000);
    n_cmp++;
    if (pc !== 16'(4 * nfetch)) begin
      n_bad++; $display("FAIL rnd_pc got=%0d exp=%0d", pc, 4 * nfetch);
    end
  endtask

  task automatic test_halt(input logic [15:0] instr, input logic ill);
    do_reset();
    step(1'b1, 1'b1, instr);
    step(1'b0, 1'b1, instr);
    step(1'b0, 1'b1, instr);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom), instr);
      n_cmp++;
      if (obs !== o_halt(ill)) begin
        n_bad++; $display("FAIL halt_%h[%0d] got=%h exp=%h", instr, i, obs, o_halt(ill));
      end
    end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    step(1'b1, 1'b1, 16'h18C7);
    step(1'b0, 1'b1, 16'h18C7);
    step(1'b0, 1'b1, 16'h18C7);
    step(1'b0, 1'b1, 16'h18C7);
    n_cmp++;
    if (obs !== o_exec(16'h18C7, 0) || d_addr !== 8'hC7 || rf_ra_addr !== 4'd8) begin
      n_bad++; $display("FAIL store got=%h exp=%h", obs, o_exec(16'h18C7, 0));
    end
    clear_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== o_init()) begin
      n_bad++; $display("FAIL store_abort got=%h exp=%h", obs, o_init());
    end
    @(negedge clock);
    clear_n = 1'b1;
    step(1'b0, 1'b1, 16'h18C7);
    n_cmp++;
    if (obs !== o_init()) begin
      n_bad++; $display("FAIL store_reinit got=%h exp=%h", obs, o_init());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_noop();
    test_load();
    test_alu_fetch_wait();
    test_random();
    test_halt(16'h5000, 1'b0);
    test_halt(16'hF000, 1'b1);
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
